// File: rtl/tile_rgb_averager_pkg.sv
// Shared types and constants for the tile RGB averager.
package tile_rgb_averager_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_SOF,
      S_ACCUM,
      S_DRAIN,
      S_DIVIDE,
      S_DONE
   } state_t;

   localparam int GRID      = 4;
   localparam int NUM_TILES = 16;

   localparam int R_MSB = 23;
   localparam int G_MSB = 15;
   localparam int B_MSB = 7;

   // A tile holds (1<<tile_log2)^2 pixels of 8 bits, so the sum needs 2*tile_log2 extra bits.
   function automatic int sum_width(input int tile_log2);
      return 8 + 2 * tile_log2;
   endfunction

endpackage

// File: rtl/tile_rgb_averager_if.sv
// Pixel stream from the camera front end.
interface tile_rgb_averager_if #(
   parameter int COORD_W = 12
);
   logic               valid;
   logic [COORD_W-1:0] x;
   logic [COORD_W-1:0] y;
   logic [7:0]         r;
   logic [7:0]         g;
   logic [7:0]         b;

   modport master (output valid, x, y, r, g, b);
   modport slave  (input  valid, x, y, r, g, b);
endinterface

// File: rtl/tile_rgb_averager_roi_tile_locator.sv
// Maps a pixel coordinate onto the 4x4 tile grid inside the ROI.
module roi_tile_locator
   import tile_rgb_averager_pkg::*;
#(
   parameter int ROI_X0    = 160,
   parameter int ROI_Y0    = 80,
   parameter int TILE_LOG2 = 6,
   parameter int COORD_W   = 12
) (
   input  logic [COORD_W-1:0] x,
   input  logic [COORD_W-1:0] y,
   output logic               in_roi,
   output logic [3:0]         tile,
   output logic               last_pixel
);

   localparam int ROI_EDGE = GRID << TILE_LOG2;
   localparam logic [COORD_W-1:0] X_LO = COORD_W'(ROI_X0);
   localparam logic [COORD_W-1:0] X_HI = COORD_W'(ROI_X0 + ROI_EDGE - 1);
   localparam logic [COORD_W-1:0] Y_LO = COORD_W'(ROI_Y0);
   localparam logic [COORD_W-1:0] Y_HI = COORD_W'(ROI_Y0 + ROI_EDGE - 1);

   logic       in_x;
   logic       in_y;
   logic [1:0] col;
   logic [1:0] row;

   // Range check first; offsets are only formed for in-ROI pixels so they never wrap.
   always_comb begin
      in_x       = (x >= X_LO) && (x <= X_HI);
      in_y       = (y >= Y_LO) && (y <= Y_HI);
      in_roi     = in_x && in_y;
      col        = 2'd0;
      row        = 2'd0;
      if (in_roi) begin
         col = 2'((x - X_LO) >> TILE_LOG2);
         row = 2'((y - Y_LO) >> TILE_LOG2);
      end
      tile       = {row, col};
      last_pixel = (x == X_HI) && (y == Y_HI);
   end

endmodule

// File: rtl/tile_rgb_averager.sv
// Captures one frame on request and produces per-tile mean colours for the sorter.
//
// state      | meaning
// S_IDLE     | waiting for i_capture; sums cleared on acceptance
// S_WAIT_SOF | waiting for pixel (0,0) of the next frame
// S_ACCUM    | pixels flowing into the tile sums; early SOF restarts
// S_DRAIN    | last ROI pixel's add lands
// S_DIVIDE   | sums shifted down into o_block*
// S_DONE     | launches the start pulse; o_start/o_busy update on the next edge
module tile_rgb_averager
   import tile_rgb_averager_pkg::*;
#(
   parameter int ROI_X0    = 160,
   parameter int ROI_Y0    = 80,
   parameter int TILE_LOG2 = 6,
   parameter int COORD_W   = 12
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_capture,
   tile_rgb_averager_if.slave  pix,
   output logic [23:0]         o_block0,  o_block1,  o_block2,  o_block3,
   output logic [23:0]         o_block4,  o_block5,  o_block6,  o_block7,
   output logic [23:0]         o_block8,  o_block9,  o_block10, o_block11,
   output logic [23:0]         o_block12, o_block13, o_block14, o_block15,
   output logic                o_start,
   output logic                o_busy
);

   localparam int SUM_W  = sum_width(TILE_LOG2);
   localparam int DIV_SH = 2 * TILE_LOG2;

   state_t     state, next_state;
   logic       clear_sums, accept, sof;
   logic       loc_in_roi, loc_last;
   logic [3:0] loc_tile;

   logic       s1_valid, s1_in_roi;
   logic [3:0] s1_tile;
   logic [7:0] s1_r, s1_g, s1_b;

   logic [SUM_W-1:0] sum_r [NUM_TILES];
   logic [SUM_W-1:0] sum_g [NUM_TILES];
   logic [SUM_W-1:0] sum_b [NUM_TILES];
   logic [23:0]      block [NUM_TILES];

   roi_tile_locator #(
      .ROI_X0    (ROI_X0),
      .ROI_Y0    (ROI_Y0),
      .TILE_LOG2 (TILE_LOG2),
      .COORD_W   (COORD_W)
   ) u_locator (
      .x          (pix.x),
      .y          (pix.y),
      .in_roi     (loc_in_roi),
      .tile       (loc_tile),
      .last_pixel (loc_last)
   );

   assign sof = pix.valid && (pix.x == '0) && (pix.y == '0);

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) state <= S_IDLE;
      else       state <= next_state;
   end

   // Next-state decode, sum clearing and pixel acceptance.
   always_comb begin
      next_state = state;
      clear_sums = 1'b0;
      accept     = 1'b0;
      case (state)
         S_IDLE: begin
            if (i_capture) begin
               next_state = S_WAIT_SOF;
               clear_sums = 1'b1;
            end
         end
         S_WAIT_SOF: begin
            if (sof) begin
               next_state = S_ACCUM;
               accept     = 1'b1;
            end
         end
         S_ACCUM: begin
            accept = 1'b1;
            if (pix.valid && loc_last) next_state = S_DRAIN;
            else if (sof)              clear_sums = 1'b1;
         end
         S_DRAIN:  next_state = S_DIVIDE;
         S_DIVIDE: next_state = S_DONE;
         S_DONE:   next_state = S_IDLE;
         default:  next_state = S_IDLE;
      endcase
   end

   // Stage 1: register the qualified pixel and its tile location.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         s1_valid  <= 1'b0;
         s1_in_roi <= 1'b0;
         s1_tile   <= 4'd0;
         s1_r      <= 8'd0;
         s1_g      <= 8'd0;
         s1_b      <= 8'd0;
      end else begin
         s1_valid  <= accept && pix.valid;
         s1_in_roi <= loc_in_roi;
         s1_tile   <= loc_tile;
         s1_r      <= pix.r;
         s1_g      <= pix.g;
         s1_b      <= pix.b;
      end
   end

   // Stage 2: accumulate into the tile sums; a clear drops any pixel of the abandoned frame.
   always_ff @(posedge i_clk) begin
      if (i_rst || clear_sums) begin
         for (int k = 0; k < NUM_TILES; k++) begin
            sum_r[k] <= '0;
            sum_g[k] <= '0;
            sum_b[k] <= '0;
         end
      end else if (s1_valid && s1_in_roi) begin
         sum_r[s1_tile] <= sum_r[s1_tile] + SUM_W'(s1_r);
         sum_g[s1_tile] <= sum_g[s1_tile] + SUM_W'(s1_g);
         sum_b[s1_tile] <= sum_b[s1_tile] + SUM_W'(s1_b);
      end
   end

   // Tile means, held until the next divide.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int k = 0; k < NUM_TILES; k++) block[k] <= 24'd0;
      end else if (state == S_DIVIDE) begin
         for (int k = 0; k < NUM_TILES; k++) begin
            block[k][R_MSB -: 8] <= 8'(sum_r[k] >> DIV_SH);
            block[k][G_MSB -: 8] <= 8'(sum_g[k] >> DIV_SH);
            block[k][B_MSB -: 8] <= 8'(sum_b[k] >> DIV_SH);
         end
      end
   end

   // Start pulse lands in the cycle busy drops.
   always_ff @(posedge i_clk) begin
      if (i_rst) o_start <= 1'b0;
      else       o_start <= (state == S_DONE);
   end

   assign o_busy = (state != S_IDLE);

   assign o_block0  = block[0];
   assign o_block1  = block[1];
   assign o_block2  = block[2];
   assign o_block3  = block[3];
   assign o_block4  = block[4];
   assign o_block5  = block[5];
   assign o_block6  = block[6];
   assign o_block7  = block[7];
   assign o_block8  = block[8];
   assign o_block9  = block[9];
   assign o_block10 = block[10];
   assign o_block11 = block[11];
   assign o_block12 = block[12];
   assign o_block13 = block[13];
   assign o_block14 = block[14];
   assign o_block15 = block[15];

endmodule

// File: tb/tb_tile_rgb_averager.sv
// Randomized frame-capture bench for tile_rgb_averager with a per-tile mean reference.
module tb_tile_rgb_averager;

   localparam int TL  = 2;
   localparam int T   = 1 << TL;
   localparam int RX0 = 0;
   localparam int RY0 = 0;
   localparam int FW  = 20;
   localparam int FH  = 20;
   localparam int CW  = 12;
   localparam int LX  = RX0 + 4 * T - 1;
   localparam int LY  = RY0 + 4 * T - 1;

   logic clk = 1'b0;
   logic rst;
   logic cap;
   logic [23:0] o_block0,  o_block1,  o_block2,  o_block3;
   logic [23:0] o_block4,  o_block5,  o_block6,  o_block7;
   logic [23:0] o_block8,  o_block9,  o_block10, o_block11;
   logic [23:0] o_block12, o_block13, o_block14, o_block15;
   logic o_start, o_busy;
   logic [23:0] blk [16];

   tile_rgb_averager_if #(.COORD_W(CW)) pix ();

   tile_rgb_averager #(
      .ROI_X0(RX0), .ROI_Y0(RY0), .TILE_LOG2(TL), .COORD_W(CW)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_capture(cap), .pix(pix),
      .o_block0(o_block0),   .o_block1(o_block1),   .o_block2(o_block2),   .o_block3(o_block3),
      .o_block4(o_block4),   .o_block5(o_block5),   .o_block6(o_block6),   .o_block7(o_block7),
      .o_block8(o_block8),   .o_block9(o_block9),   .o_block10(o_block10), .o_block11(o_block11),
      .o_block12(o_block12), .o_block13(o_block13), .o_block14(o_block14), .o_block15(o_block15),
      .o_start(o_start), .o_busy(o_busy)
   );

   assign blk[0]  = o_block0;  assign blk[1]  = o_block1;  assign blk[2]  = o_block2;  assign blk[3]  = o_block3;
   assign blk[4]  = o_block4;  assign blk[5]  = o_block5;  assign blk[6]  = o_block6;  assign blk[7]  = o_block7;
   assign blk[8]  = o_block8;  assign blk[9]  = o_block9;  assign blk[10] = o_block10; assign blk[11] = o_block11;
   assign blk[12] = o_block12; assign blk[13] = o_block13; assign blk[14] = o_block14; assign blk[15] = o_block15;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int   n_start = 0;
   int   start_cyc = 0;
   logic busy_at_start = 1'b0;
   bit   busy_watch = 1'b0;
   int   busy_drop = 0;

   // Start pulses and busy continuity, observed mid-cycle.
   always @(negedge clk) begin
      if (o_start === 1'b1) begin
         n_start++;
         start_cyc     = cyc;
         busy_at_start = o_busy;
         busy_watch    = 1'b0;
      end else if (busy_watch && o_busy !== 1'b1) begin
         busy_drop++;
      end
   end

   logic [7:0] fr_r [FH][FW];
   logic [7:0] fr_g [FH][FW];
   logic [7:0] fr_b [FH][FW];
   int last_edge = 0;
   int frame_k   = 0;
   int checks    = 0;
   int errors    = 0;

   // Reference: plain mean of the tile's pixels, truncated.
   function automatic logic [23:0] exp_block(input int k);
      int row = k / 4;
      int col = k % 4;
      int sr = 0, sg = 0, sb = 0;
      for (int j = 0; j < T; j++)
         for (int i = 0; i < T; i++) begin
            sr += fr_r[RY0 + row * T + j][RX0 + col * T + i];
            sg += fr_g[RY0 + row * T + j][RX0 + col * T + i];
            sb += fr_b[RY0 + row * T + j][RX0 + col * T + i];
         end
      return {8'(sr / (T * T)), 8'(sg / (T * T)), 8'(sb / (T * T))};
   endfunction

   task automatic fill_random();
      for (int y = 0; y < FH; y++)
         for (int x = 0; x < FW; x++) begin
            fr_r[y][x] = 8'($urandom);
            fr_g[y][x] = 8'($urandom);
            fr_b[y][x] = 8'($urandom);
         end
   endtask

   task automatic step(input bit v, input int x, input int y, input int cap_at);
      @(posedge clk); #1;
      cap = (cap_at >= 0) && (frame_k == cap_at || frame_k == cap_at + 10);
      if (cap_at >= 0 && frame_k == cap_at + 1) busy_watch = 1'b1;
      pix.valid = v;
      pix.x     = CW'(x);
      pix.y     = CW'(y);
      if (v) begin
         pix.r = fr_r[y][x];
         pix.g = fr_g[y][x];
         pix.b = fr_b[y][x];
      end else begin
         pix.r = 8'($urandom);
         pix.g = 8'($urandom);
         pix.b = 8'($urandom);
      end
      if (v && x == LX && y == LY) last_edge = cyc + 1;
      frame_k++;
   endtask

   task automatic send_frame(input int rows, input int gap_pct, input int cap_at);
      frame_k = 0;
      for (int y = 0; y < rows; y++)
         for (int x = 0; x < FW; x++) begin
            while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) step(1'b0, x, y, cap_at);
            step(1'b1, x, y, cap_at);
         end
      step(1'b0, 0, 0, -1);
   endtask

   task automatic pulse_capture();
      @(posedge clk); #1 cap = 1'b1;
      @(posedge clk); #1 cap = 1'b0;
      busy_watch = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++; if (o_start !== 1'b0) begin errors++; $display("FAIL reset_start got %b exp 0", o_start); end
      checks++; if (o_busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b exp 0", o_busy); end
      for (int k = 0; k < 16; k++) begin
         checks++;
         if (blk[k] !== 24'h0) begin errors++; $display("FAIL reset_block%0d got %h exp 000000", k, blk[k]); end
      end
   endtask

   task automatic test_uniform();
      int n0;
      for (int y = 0; y < FH; y++)
         for (int x = 0; x < FW; x++) begin
            fr_r[y][x] = 8'h10; fr_g[y][x] = 8'h20; fr_b[y][x] = 8'h30;
         end
      n0 = n_start; busy_drop = 0;
      pulse_capture();
      send_frame(FH, 0, -1);
      repeat (8) @(negedge clk);
      checks++; if (n_start - n0 != 1) begin errors++; $display("FAIL uniform_nstart got %0d exp 1", n_start - n0); end
      checks++; if (start_cyc != last_edge + 3) begin errors++; $display("FAIL uniform_latency got %0d exp %0d", start_cyc, last_edge + 3); end
      checks++; if (busy_drop != 0 || busy_at_start !== 1'b0) begin errors++; $display("FAIL uniform_busy drops %0d busy_at_start %b exp 0/0", busy_drop, busy_at_start); end
      for (int k = 0; k < 16; k++) begin
         checks++;
         if (blk[k] !== exp_block(k)) begin errors++; $display("FAIL uniform_block%0d got %h exp %h", k, blk[k], exp_block(k)); end
      end
   endtask

   task automatic test_distinct();
      int n0;
      for (int y = 0; y < FH; y++)
         for (int x = 0; x < FW; x++) begin
            if (x >= RX0 && x <= LX && y >= RY0 && y <= LY) begin
               int k = ((y - RY0) / T) * 4 + (x - RX0) / T;
               fr_r[y][x] = 8'(k); fr_g[y][x] = 8'(2 * k); fr_b[y][x] = 8'(255 - k);
            end else begin
               fr_r[y][x] = 8'hFF; fr_g[y][x] = 8'hFF; fr_b[y][x] = 8'hFF;
            end
         end
      n0 = n_start; busy_drop = 0;
      pulse_capture();
      send_frame(FH, 0, -1);
      repeat (8) @(negedge clk);
      checks++; if (n_start - n0 != 1) begin errors++; $display("FAIL distinct_nstart got %0d exp 1", n_start - n0); end
      for (int k = 0; k < 16; k++) begin
         checks++;
         if (blk[k] !== exp_block(k)) begin errors++; $display("FAIL distinct_block%0d got %h exp %h", k, blk[k], exp_block(k)); end
      end
   endtask

   task automatic test_truncation();
      int n0;
      for (int y = 0; y < FH; y++)
         for (int x = 0; x < FW; x++) begin
            fr_r[y][x] = 8'h00; fr_g[y][x] = 8'h00; fr_b[y][x] = 8'h00;
         end
      for (int y = RY0 + T; y < RY0 + 2 * T; y++)
         for (int x = RX0 + T; x < RX0 + 2 * T; x++)
            fr_r[y][x] = ((x + y) % 2 == 0) ? 8'h01 : 8'h02;
      n0 = n_start; busy_drop = 0;
      pulse_capture();
      send_frame(FH, 0, -1);
      repeat (8) @(negedge clk);
      checks++; if (n_start - n0 != 1) begin errors++; $display("FAIL trunc_nstart got %0d exp 1", n_start - n0); end
      checks++; if (blk[5] !== 24'h010000) begin errors++; $display("FAIL trunc_block5 got %h exp 010000", blk[5]); end
      for (int k = 0; k < 16; k++) begin
         checks++;
         if (blk[k] !== exp_block(k)) begin errors++; $display("FAIL trunc_block%0d got %h exp %h", k, blk[k], exp_block(k)); end
      end
   endtask

   task automatic test_gapped();
      int n0;
      fill_random();
      n0 = n_start; busy_drop = 0;
      pulse_capture();
      send_frame(FH, 50, -1);
      repeat (8) @(negedge clk);
      checks++; if (n_start - n0 != 1) begin errors++; $display("FAIL gapped_nstart got %0d exp 1", n_start - n0); end
      checks++; if (start_cyc != last_edge + 3) begin errors++; $display("FAIL gapped_latency got %0d exp %0d", start_cyc, last_edge + 3); end
      checks++; if (busy_drop != 0) begin errors++; $display("FAIL gapped_busy drops got %0d exp 0", busy_drop); end
      for (int k = 0; k < 16; k++) begin
         checks++;
         if (blk[k] !== exp_block(k)) begin errors++; $display("FAIL gapped_block%0d got %h exp %h", k, blk[k], exp_block(k)); end
      end
   endtask

   task automatic test_capture_midframe();
      int n0;
      fill_random();
      n0 = n_start; busy_drop = 0; busy_watch = 1'b0;
      send_frame(FH, 0, 150);
      checks++; if (n_start != n0) begin errors++; $display("FAIL midframe_early_start got %0d exp 0", n_start - n0); end
      checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL midframe_busy got %b exp 1", o_busy); end
      fill_random();
      send_frame(FH, 0, -1);
      repeat (20) @(negedge clk);
      checks++; if (n_start - n0 != 1) begin errors++; $display("FAIL midframe_nstart got %0d exp 1", n_start - n0); end
      checks++; if (start_cyc != last_edge + 3) begin errors++; $display("FAIL midframe_latency got %0d exp %0d", start_cyc, last_edge + 3); end
      checks++; if (busy_drop != 0) begin errors++; $display("FAIL midframe_busy drops got %0d exp 0", busy_drop); end
      for (int k = 0; k < 16; k++) begin
         checks++;
         if (blk[k] !== exp_block(k)) begin errors++; $display("FAIL midframe_block%0d got %h exp %h", k, blk[k], exp_block(k)); end
      end
   endtask

   task automatic test_reset_truncated();
      int n0;
      fill_random();
      n0 = n_start;
      pulse_capture();
      send_frame(10, 0, -1);
      busy_watch = 1'b0;
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b exp 0", o_busy); end
      for (int k = 0; k < 16; k++) begin
         checks++;
         if (blk[k] !== 24'h0) begin errors++; $display("FAIL rst_mid_block%0d got %h exp 000000", k, blk[k]); end
      end
      repeat (20) @(negedge clk);
      checks++; if (n_start != n0) begin errors++; $display("FAIL rst_mid_nstart got %0d exp 0", n_start - n0); end
      busy_drop = 0;
      pulse_capture();
      send_frame(8, 0, -1);
      fill_random();
      send_frame(FH, 25, -1);
      repeat (8) @(negedge clk);
      checks++; if (n_start - n0 != 1) begin errors++; $display("FAIL restart_nstart got %0d exp 1", n_start - n0); end
      checks++; if (start_cyc != last_edge + 3) begin errors++; $display("FAIL restart_latency got %0d exp %0d", start_cyc, last_edge + 3); end
      checks++; if (busy_drop != 0) begin errors++; $display("FAIL restart_busy drops got %0d exp 0", busy_drop); end
      for (int k = 0; k < 16; k++) begin
         checks++;
         if (blk[k] !== exp_block(k)) begin errors++; $display("FAIL restart_block%0d got %h exp %h", k, blk[k], exp_block(k)); end
      end
   endtask

   initial begin
      rst = 1'b1; cap = 1'b0;
      pix.valid = 1'b0; pix.x = '0; pix.y = '0;
      pix.r = 8'h00; pix.g = 8'h00; pix.b = 8'h00;
      test_reset();
      test_uniform();
      test_distinct();
      test_truncation();
      test_gapped();
      test_capture_midframe();
      test_reset_truncated();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
